// File: rtl/pipe_scoreboard_if.sv
// Decode/datapath <-> scoreboard bundle: issue info, read selects,
// advance/flush controls in; forwarding selects, stall and counters out.
interface pipe_scoreboard_if #(
  parameter int NSTAGES = 3,
  parameter int NREAD   = 2,
  parameter int REGADDR = 5,
  parameter int CNTW    = 32
);
  localparam int SELW = $clog2(NSTAGES + 1);

  logic                      advance;
  logic                      issue_valid;
  logic                      issue_wen;
  logic [REGADDR-1:0]        issue_wsel;
  logic [SELW-1:0]           issue_lat;
  logic [NREAD*REGADDR-1:0]  rsel;
  logic [NSTAGES-1:0]        flush;
  logic [NREAD*SELW-1:0]     fwd_sel;
  logic                      stall;
  logic [SELW-1:0]           pending;
  logic [CNTW-1:0]           stall_cycles;

  // Decode/datapath side
  modport master (
    output advance, issue_valid, issue_wen, issue_wsel, issue_lat, rsel, flush,
    input  fwd_sel, stall, pending, stall_cycles
  );

  // Scoreboard side
  modport slave (
    input  advance, issue_valid, issue_wen, issue_wsel, issue_lat, rsel, flush,
    output fwd_sel, stall, pending, stall_cycles
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding tracker: one in-flight record per post-decode stage
// (index 0 = EX, NSTAGES-1 = WB). Produces per-port forwarding selects,
// a load-use stall, a valid-entry count and a saturating stall counter.
module pipe_scoreboard #(
  parameter int NSTAGES = 3,
  parameter int NREAD   = 2,
  parameter int REGADDR = 5,
  parameter int CNTW    = 32
) (
  input logic              CLK,
  input logic              RST,
  pipe_scoreboard_if.slave sb
);
  localparam int SELW = $clog2(NSTAGES + 1);

  // Entry state; a valid entry always has wen set (non-writers never enter)
  logic [NSTAGES-1:0] valid_q, valid_d;
  logic [REGADDR-1:0] wsel_q [NSTAGES];
  logic [REGADDR-1:0] wsel_d [NSTAGES];
  logic [SELW-1:0]    lat_q  [NSTAGES];
  logic [SELW-1:0]    lat_d  [NSTAGES];
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [NREAD-1:0]      port_stall;
  logic [NREAD*SELW-1:0] fwd_all;
  logic                  stall_c;
  logic [SELW-1:0]       pending_c;

  for (genvar gp = 0; gp < NREAD; gp++) begin : g_port
    logic [REGADDR-1:0] rsel_p;
    logic [SELW-1:0]    fwd_p;
    logic               stall_p;
    logic               found;

    assign rsel_p = sb.rsel[gp*REGADDR +: REGADDR];

    // Youngest (lowest-index) match decides: forward if its result is ready, else stall
    always_comb begin
      fwd_p   = '0;
      stall_p = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < NSTAGES; i++) begin
        if (!found && valid_q[i] && (wsel_q[i] == rsel_p) && (rsel_p != '0)) begin
          found = 1'b1;
          if (SELW'(i) >= lat_q[i]) begin
            fwd_p = SELW'(i + 1);
          end else begin
            stall_p = 1'b1;
          end
        end
      end
    end

    assign fwd_all[gp*SELW +: SELW] = fwd_p;
    assign port_stall[gp]           = stall_p;
  end

  assign stall_c = |port_stall;

  // Count valid entries
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      pending_c = pending_c + SELW'(valid_q[i]);
    end
  end

  // Next entry state: kill applies to the source entry before any shift
  always_comb begin
    valid_d = valid_q & ~sb.flush;
    for (int i = 0; i < NSTAGES; i++) begin
      wsel_d[i] = wsel_q[i];
      lat_d[i]  = lat_q[i];
    end
    if (sb.advance) begin
      for (int i = 1; i < NSTAGES; i++) begin
        valid_d[i] = valid_q[i-1] & ~sb.flush[i-1];
        wsel_d[i]  = wsel_q[i-1];
        lat_d[i]   = lat_q[i-1];
      end
      valid_d[0] = sb.issue_valid & sb.issue_wen & ~stall_c & ~sb.flush[0];
      wsel_d[0]  = sb.issue_wsel;
      lat_d[0]   = sb.issue_lat;
    end
  end

  // Saturating count of cycles that stalled while the pipe advanced
  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && sb.advance && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Entry registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      for (int i = 0; i < NSTAGES; i++) begin
        wsel_q[i] <= '0;
        lat_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NSTAGES; i++) begin
        wsel_q[i] <= wsel_d[i];
        lat_q[i]  <= lat_d[i];
      end
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sb.fwd_sel      = fwd_all;
  assign sb.stall        = stall_c;
  assign sb.pending      = pending_c;
  assign sb.stall_cycles = cnt_q;
endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard/forwarding tracker for the pipelined MIPS core; generalises the current fixed stall/flush logic to N execute-side stages and M register read ports.
- Holds one in-flight record per post-decode stage: valid, destination register, result latency.
- Produces per-read-port forwarding selects, a combined load-use stall and a saturating stall-cycle counter.
- Sits beside decode. Decode supplies issued-instruction info and read selects; the datapath supplies advance/flush.

Parameters:
NSTAGES, 3, number of tracked stages after decode; index 0 = EX, NSTAGES-1 = WB
NREAD, 2, number of register read ports checked per cycle
REGADDR, 5, register select width
SELW, $clog2(NSTAGES+1), forwarding select width (derived, not overridden)
CNTW, 32, stall counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
advance  in  1  pipeline moves this cycle (ihit/dhit qualified); 0 = hold all entries
issue_valid  in  1  decode holds a real instruction
issue_wen  in  1  issued instruction writes a register
issue_wsel  in  REGADDR  issued destination register
issue_lat  in  SELW  stage index from which the result is forwardable (ALU = 1, load = 2)
rsel  in  NREAD*REGADDR  read selects, port p at [p*REGADDR +: REGADDR]
flush  in  NSTAGES  per-stage kill mask, bit i invalidates entry i
fwd_sel  out  NREAD*SELW  per port: 0 = register file, k = forward from entry k-1
stall  out  1  load-use hazard; decode must not issue
pending  out  SELW  count of valid entries
stall_cycles  out  CNTW  saturating count of cycles with stall=1 and advance=1

Behaviour:
- Reset (RST=1, async): all entries invalid, wsel=0, lat=0; stall_cycles=0. Outputs are then fwd_sel=0, stall=0, pending=0.
- Entry i is "matching" for port p when:
  - entry valid and wen, and
  - wsel == rsel[p], and
  - rsel[p] != 0 (register 0 never matches, never stalls).
- Youngest match wins: the lowest index among matching entries.
- Port p with youngest match at entry i:
  - if i >= lat: fwd_sel[p] = i+1, no stall contribution;
  - else: fwd_sel[p] = 0 and the port asserts stall.
- No match: fwd_sel[p] = 0.
- stall = OR over ports; combinational from current entries and rsel. It does not depend on issue_valid, and decode gates it.
- Clock edge, advance=1:
  - entry[i+1] <= entry[i] for i < NSTAGES-1, with each shifted entry's valid AND ~flush[i];
  - the oldest entry is discarded;
  - entry[0] <= {issue_valid & issue_wen & ~stall & ~flush[0], issue_wsel, issue_lat}.
  - A stalled or flushed issue inserts a bubble (valid=0).
- Clock edge, advance=0:
  - entries hold;
  - flush bits still clear valid in place (entry[i].valid &= ~flush[i]);
  - no issue is captured.
- Simultaneous flush and advance: the kill is applied to the source entry before the shift. flush[NSTAGES-1] therefore affects only the hold case.
- issue_lat >= NSTAGES: the entry is never forwardable. Any matching reader stalls until the entry retires; this is legal and used for multi-cycle units.
- pending = popcount of entry valid bits, combinational.
- stall_cycles: increments when stall & advance, saturates at all-ones, never wraps. It is cleared only by RST.
- Multiple ports may forward from the same entry in the same cycle.
- Reset asserted mid-operation clears all state immediately, independent of CLK.

Test Plan:
1. ALU chain: issue wsel=8, lat=1, advance each cycle. Next cycle rsel0=8 -> stall=1 (entry 0, lat 1). Following cycle rsel0=8 -> fwd_sel0=2, stall=0. After 3 advances -> fwd_sel0=0, pending=0.
2. Load-use: issue wsel=9, lat=2. Next cycle rsel1=9 -> stall=1 and bubble inserted. Next two cycles -> stall=1 then fwd_sel1=3. stall_cycles = 2.
3. Youngest wins: entries hold wsel=4 at index 2 and index 1, both forwardable; rsel0=4 -> fwd_sel0=2.
4. Register 0: issue wsel=0, wen=1; rsel0=rsel1=0 -> fwd_sel=0, stall=0 in all cycles.
5. Flush with hold: pending=3, advance=0, flush=3'b011 -> after the edge pending=1, only entry 2 is valid. Then advance=1, flush=3'b100 -> entry 2 dropped, pending counts only new issue.
6. Async reset: pending=2, stall_cycles=5. Assert RST between clock edges -> pending=0, stall_cycles=0 immediately; outputs stay 0 until RST deasserts and a new issue occurs.
